dff_capture_arbiter: RTL
========================

// Module: dff_capture_arbiter
// PURPOSE
//  Shares one synchronous capture flip-flop among NUM_REQ requesters.
//  Each requester presents a request and a 1-bit data value.
//  A round-robin arbiter grants one requester at a time. The FSM captures that
//  requester's bit into the shared register and holds ownership for HOLD_CYCLES.
//  Sits between the ui_in-sourced request/data pins and the uo_out sample output.
// PARAMETERS
//  NUM_REQ      4  number of requesters, 2..8
//  HOLD_CYCLES  3  cycles the owner keeps the grant after capture, 1..15
// PORTS
//  clk      in   1                  single clock, all logic on rising edge
//  rst      in   1                  synchronous reset, active-high
//  req      in   NUM_REQ            per-requester request, level
//  din      in   NUM_REQ            per-requester data bit
//  grant    out  NUM_REQ            one-hot grant, registered
//  q        out  1                  shared captured bit
//  q_valid  out  1                  1-cycle pulse: q was updated this cycle
//  q_owner  out  $clog2(NUM_REQ)    index of requester that produced q
//  busy     out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at an edge) produces, from the next cycle:
//    state=IDLE, grant=0, q=0, q_valid=0, q_owner=0, busy=0, rr_ptr=0.
//    This applies in any state, including mid-GRANT/HOLD; no q_valid is emitted.
//  - FSM states: IDLE, GRANT, HOLD.
//  - IDLE:
//    - Cycle T with any req bit set: pick the first set bit scanning rr_ptr, rr_ptr+1, ...
//      The scan wraps modulo NUM_REQ.
//    - At T+1: grant is one-hot on the winner, state=GRANT.
//    - No req set: stay in IDLE, grant=0.
//  - GRANT (exactly 1 cycle):
//    - If req[owner]=1: q<=din[owner] and q_owner<=owner.
//      At T+2: q_valid=1 and state=HOLD.
//      rr_ptr<=(owner+1) mod NUM_REQ.
//    - If req[owner]=0 (withdrawn): abort. q, q_owner and rr_ptr are unchanged.
//      No q_valid. At T+2: grant=0, state=IDLE.
//  - HOLD:
//    - grant stays asserted. The counter loads HOLD_CYCLES-1 on entry and decrements.
//    - The state leaves HOLD after HOLD_CYCLES cycles (T+2 .. T+1+HOLD_CYCLES).
//      Then grant=0 and state=IDLE.
//    - Early release: if req[owner]=0 in any HOLD cycle, grant=0 and state=IDLE next cycle.
//  - Turnaround: at least one IDLE cycle (grant=0) between consecutive grants.
//    This holds even for the same requester, so there are no glitch-free handover issues.
//  - q and q_owner hold their values between captures.
//    q_valid is high only in the first HOLD cycle.
//  - din of non-owners is ignored. din[owner] is sampled only at the GRANT edge.
//  - Requests are not queued. A requester must hold req until it is granted.
//  - The counter is 4 bits wide. q_owner is $clog2(NUM_REQ) bits wide.
//    rr_ptr arithmetic wraps modulo NUM_REQ (NUM_REQ need not be a power of 2).
// TESTING (NUM_REQ=4, HOLD_CYCLES=3)
//  1. Reset: rst=1 for 2 cycles with req=4'b1111.
//     -> grant=0, q=0, q_valid=0, busy=0 throughout.
//  2. Single request: req=4'b0100 and din=4'b0100 from cycle T.
//     -> grant=4'b0100 at T+1..T+4; q=1, q_owner=2, q_valid=1 at T+2 only;
//        grant=0 at T+5.
//  3. Round robin: req=4'b1111 held, din=4'b1010.
//     -> owners in order 0,1,2,3,0 with q=0,1,0,1,0.
//     -> exactly one IDLE cycle between grants.
//  4. Abort: req=4'b0010, then req drops in the GRANT cycle.
//     -> no q_valid; q and q_owner unchanged; grant=0 and busy=0 the next cycle.
//     -> the next grant still starts the scan at the old rr_ptr.
//  5. Early release: req[3] granted, then dropped in the 2nd HOLD cycle.
//     -> grant=0 the next cycle; req[0] pending is granted one cycle after that.
//  6. Reset mid-HOLD: rst=1 in the 1st HOLD cycle.
//     -> next cycle all outputs are at reset values and rr_ptr=0.
//     -> with req=4'b1111, the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/dff_capture_arbiter.sv
// Round-robin arbiter sharing one capture flip-flop among NUM_REQ requesters.
// The winner's data bit is captured once, then the grant is held for HOLD_CYCLES.
module dff_capture_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = 3,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] grant,
  output logic               q,
  output logic               q_valid,
  output logic [IDX_W-1:0]   q_owner,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [3:0]       hold_cnt;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W:0]   cand;
  logic             owner_req;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Pointer advance wraps at NUM_REQ, which need not be a power of two.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == LAST_IDX) ptr_inc = '0;
    else               ptr_inc = p + IDX_W'(1);
  endfunction

  assign owner_req = req[owner];

  // Round-robin scan: first set request at rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    win_idx   = rr_ptr;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_idx   = cand[IDX_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (win_found) next_state = S_GRANT;
      S_GRANT: next_state = owner_req ? S_HOLD : S_IDLE;
      S_HOLD:  if (!owner_req || hold_cnt == 4'd0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Grant, capture register, owner tracking and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      q        <= 1'b0;
      q_valid  <= 1'b0;
      q_owner  <= '0;
    end else begin
      q_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            owner <= win_idx;
            grant <= onehot(win_idx);
          end
        end
        S_GRANT: begin
          if (owner_req) begin
            q        <= din[owner];
            q_owner  <= owner;
            q_valid  <= 1'b1;
            rr_ptr   <= ptr_inc(owner);
            hold_cnt <= HOLD_LOAD;
          end else begin
            // Withdrawn before capture: drop the grant, keep pointer and data.
            grant <= '0;
          end
        end
        S_HOLD: begin
          if (next_state == S_IDLE) grant    <= '0;
          else                      hold_cnt <= hold_cnt - 4'd1;
        end
        default: grant <= '0;
      endcase
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid_in_hold: assert property (@(posedge clk) disable iff (rst) q_valid |-> state == S_HOLD);
  a_busy_grant:    assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));

endmodule
